// File: rtl/regfile_pkg.sv
// Shared constants for the decoded register file: default widths, register-count
// derivation and the hardwired-zero register index.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX   = 0;

  function automatic int nreg(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_decoded_if.sv
// Writeback/decode-side bus of the register file: write port, two read ports
// and the registered write trace.
interface regfile_decoded_if
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  localparam int NREG = nreg(ADDR_W);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [XLEN-1:0]   wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [XLEN-1:0]   rdata1;
  logic [XLEN-1:0]   rdata2;
  logic [NREG-1:0]   wr_onehot;
  logic              wr_valid;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2, wr_onehot, wr_valid
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2, wr_onehot, wr_valid
  );

endinterface

// File: rtl/regfile_decoded_decoder_n.sv
// Generic N-to-2^N one-hot decoder with enable; all outputs low when disabled.
module decoder_n #(
  parameter int N_IN = 5
) (
  input  logic [N_IN-1:0]      in,
  input  logic                 en,
  output logic [(2**N_IN)-1:0] out
);

  // One output bit per index, set only when enabled and selected
  always_comb begin
    out = '0;
    for (int i = 0; i < (2**N_IN); i++) begin
      if (en && (in == N_IN'(i))) begin
        out[i] = 1'b1;
      end else begin
        out[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_decoded.sv
// Parametrised RISC-V integer register file: one write port, two combinational
// read ports, registered write trace. Define REGFILE_BYPASS_EN for write-first forwarding.
module regfile_decoded
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_decoded_if.slave bus
);

  localparam int NREG = nreg(ADDR_W);

  logic [NREG-1:0] dec_s;
  logic [NREG-1:0] mdec_s;
  logic [XLEN-1:0] regs_r [NREG];
  logic [NREG-1:0] wr_onehot_r;
  logic            wr_valid_r;
  logic [XLEN-1:0] rd1_s;
  logic [XLEN-1:0] rd2_s;
  logic            zero_rd1_s;
  logic            zero_rd2_s;

  decoder_n #(.N_IN(ADDR_W)) u_dec (
    .in  (bus.waddr),
    .en  (bus.we),
    .out (dec_s)
  );

  // Suppress the write strobe of the hardwired-zero register
  always_comb begin
    mdec_s = dec_s;
    if (ZERO_REG != 0) begin
      mdec_s[ZERO_IDX] = 1'b0;
    end else begin
      mdec_s = dec_s;
    end
  end

  // Register storage: commit WDATA into the single strobed entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (mdec_s[i]) begin
          regs_r[i] <= bus.wdata;
        end
      end
    end
  end

  // Write trace: one-hot and valid of the write committed on this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_onehot_r <= '0;
      wr_valid_r  <= 1'b0;
    end else begin
      wr_onehot_r <= mdec_s;
      wr_valid_r  <= |mdec_s;
    end
  end

  assign zero_rd1_s = (ZERO_REG != 0) && (bus.raddr1 == ADDR_W'(ZERO_IDX));
  assign zero_rd2_s = (ZERO_REG != 0) && (bus.raddr2 == ADDR_W'(ZERO_IDX));

  // Read muxes; the masked strobe already excludes index 0 from forwarding
  always_comb begin
    rd1_s = '0;
    rd2_s = '0;
    if (zero_rd1_s) begin
      rd1_s = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (mdec_s[bus.raddr1]) begin
      rd1_s = bus.wdata;
`endif
    end else begin
      rd1_s = regs_r[bus.raddr1];
    end
    if (zero_rd2_s) begin
      rd2_s = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (mdec_s[bus.raddr2]) begin
      rd2_s = bus.wdata;
`endif
    end else begin
      rd2_s = regs_r[bus.raddr2];
    end
  end

  assign bus.rdata1    = rd1_s;
  assign bus.rdata2    = rd2_s;
  assign bus.wr_onehot = wr_onehot_r;
  assign bus.wr_valid  = wr_valid_r;

endmodule

// File: tb/tb_regfile_decoded.sv
// Bench for regfile_decoded: default 32x32 build with x0 hardwired, plus a
// 8x16 build with ordinary x0, checked against an array model every cycle.
module tb_regfile_decoded;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  regfile_decoded_if #(.XLEN(32), .ADDR_W(5)) b32 ();
  regfile_decoded_if #(.XLEN(16), .ADDR_W(3)) b8 ();

  regfile_decoded #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32)
  );

  regfile_decoded #(.XLEN(16), .ADDR_W(3), .ZERO_REG(0)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain arrays plus the expected trace of the last edge
  logic [31:0] m32 [32];
  logic [15:0] m8  [8];
  logic [31:0] eoh32;
  logic        ev32;
  logic [7:0]  eoh8;
  logic        ev8;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m32[i] <= 32'h0;
      for (int i = 0; i < 8; i++)  m8[i]  <= 16'h0;
      eoh32 <= 32'h0;
      ev32  <= 1'b0;
      eoh8  <= 8'h0;
      ev8   <= 1'b0;
    end else begin
      if (b32.we && b32.waddr != 5'd0) begin
        m32[b32.waddr] <= b32.wdata;
        eoh32          <= 32'd1 << b32.waddr;
        ev32           <= 1'b1;
      end else begin
        eoh32 <= 32'h0;
        ev32  <= 1'b0;
      end
      if (b8.we) begin
        m8[b8.waddr] <= b8.wdata;
        eoh8         <= 8'd1 << b8.waddr;
        ev8          <= 1'b1;
      end else begin
        eoh8 <= 8'h0;
        ev8  <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_rd32(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (b32.we && a == b32.waddr) return b32.wdata;
`endif
    return m32[a];
  endfunction

  function automatic logic [15:0] exp_rd8(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
    if (b8.we && a == b8.waddr) return b8.wdata;
`endif
    return m8[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs against the model at every falling edge
  always @(negedge clk) begin
    check("cyc_rd1_32", b32.rdata1, exp_rd32(b32.raddr1));
    check("cyc_rd2_32", b32.rdata2, exp_rd32(b32.raddr2));
    check("cyc_oh_32", b32.wr_onehot, eoh32);
    check("cyc_v_32", {31'h0, b32.wr_valid}, {31'h0, ev32});
    check("cyc_rd1_8", {16'h0, b8.rdata1}, {16'h0, exp_rd8(b8.raddr1)});
    check("cyc_rd2_8", {16'h0, b8.rdata2}, {16'h0, exp_rd8(b8.raddr2)});
    check("cyc_oh_8", {24'h0, b8.wr_onehot}, {24'h0, eoh8});
    check("cyc_v_8", {31'h0, b8.wr_valid}, {31'h0, ev8});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    b32.we = 1'b0; b32.waddr = 5'd0; b32.wdata = 32'h0; b32.raddr1 = 5'd5; b32.raddr2 = 5'd0;
    b8.we  = 1'b0; b8.waddr  = 3'd0; b8.wdata  = 16'h0; b8.raddr1  = 3'd0; b8.raddr2  = 3'd0;
    #2;
    check("rst_rd1", b32.rdata1, 32'h0);
    check("rst_valid", {31'h0, b32.wr_valid}, 32'h0);
    check("rst_onehot", b32.wr_onehot, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Basic write then idle
    b32.we = 1'b1; b32.waddr = 5'd3; b32.wdata = 32'h12345678; b32.raddr2 = 5'd3;
    step();
    b32.we = 1'b0;
    #1;
    check("basic_valid", {31'h0, b32.wr_valid}, 32'h1);
    check("basic_onehot", b32.wr_onehot, 32'h00000008);
    check("basic_rd2", b32.rdata2, 32'h12345678);
    step();
    check("idle_valid", {31'h0, b32.wr_valid}, 32'h0);
    check("idle_onehot", b32.wr_onehot, 32'h0);

    // x0 protection
    b32.we = 1'b1; b32.waddr = 5'd0; b32.wdata = 32'hFFFFFFFF; b32.raddr1 = 5'd0;
    step();
    b32.we = 1'b0;
    #1;
    check("x0_rd1", b32.rdata1, 32'h0);
    check("x0_valid", {31'h0, b32.wr_valid}, 32'h0);
    check("x0_onehot", b32.wr_onehot, 32'h0);

    // Same-cycle hazard on x7
    b32.we = 1'b1; b32.waddr = 5'd7; b32.wdata = 32'h1;
    step();
    b32.wdata = 32'h2; b32.raddr1 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("hazard_pre", b32.rdata1, 32'h2);
`else
    check("hazard_pre", b32.rdata1, 32'h1);
`endif
    step();
    b32.we = 1'b0;
    #1;
    check("hazard_post", b32.rdata1, 32'h2);

    // Sweep x1..x31
    for (int i = 1; i < 32; i++) begin
      b32.we = 1'b1; b32.waddr = 5'(i); b32.wdata = 32'(i) * 32'h01010101;
      step();
      check("sweep_onehot", b32.wr_onehot, 32'd1 << i);
    end
    b32.we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b32.raddr1 = 5'(i); b32.raddr2 = 5'(31 - i);
      #1;
      check("sweep_rd1", b32.rdata1, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
      check("sweep_rd2", b32.rdata2, (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101);
    end
    b32.raddr1 = 5'd9; b32.raddr2 = 5'd9;
    #1;
    check("same_idx", b32.rdata1, 32'h09090909);
    check("same_idx2", b32.rdata2, 32'h09090909);

    // Narrow build with ordinary x0
    step();
    b8.we = 1'b1; b8.waddr = 3'd0; b8.wdata = 16'hABCD;
    step();
    b8.waddr = 3'd7; b8.wdata = 16'h1234;
    check("n8_oh0", {24'h0, b8.wr_onehot}, 32'h01);
    check("n8_v0", {31'h0, b8.wr_valid}, 32'h1);
    step();
    b8.we = 1'b0; b8.raddr1 = 3'd0; b8.raddr2 = 3'd7;
    #1;
    check("n8_oh7", {24'h0, b8.wr_onehot}, 32'h80);
    check("n8_rd0", {16'h0, b8.rdata1}, 32'hABCD);
    check("n8_rd7", {16'h0, b8.rdata2}, 32'h1234);

    // Asynchronous reset mid-cycle after writing x5
    b32.we = 1'b1; b32.waddr = 5'd5; b32.wdata = 32'hDEADBEEF;
    step();
    b32.we = 1'b0; b32.raddr1 = 5'd5; b32.raddr2 = 5'd3;
    #1;
    check("pre_rst_x5", b32.rdata1, 32'hDEADBEEF);
    b32.we = 1'b1; b32.waddr = 5'd9; b32.wdata = 32'hCAFEF00D;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd1", b32.rdata1, 32'h0);
    check("mid_rst_rd2", b32.rdata2, 32'h0);
    check("mid_rst_valid", {31'h0, b32.wr_valid}, 32'h0);
    check("mid_rst_onehot", b32.wr_onehot, 32'h0);
    check("mid_rst_n8", {16'h0, b8.rdata1}, 32'h0);
    step();
    b32.we = 1'b0;
    rst_n = 1'b1;
    b32.raddr1 = 5'd9;
    #1;
    check("rst_discard", b32.rdata1, 32'h0);
    step();
    check("post_rst_valid", {31'h0, b32.wr_valid}, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_decoded.md
Name: regfile_decoded

Overview:
- Parametrised integer register file for the RISC-V datapath: one synchronous write port, two combinational read ports, register 0 hardwired to zero.
- Write enables come from a generic N-to-2^N one-hot decoder that generalises the fixed 5-to-32 decoder.
- Adds a registered write-trace output and an optional write-to-read bypass.
- Sits between the decode stage (read addresses) and the writeback stage (write address/data).

Parameters:
- XLEN, 32, data width of each register.
- ADDR_W, 5, register address width; register count NREG = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary storage.

Ports:
- CLK  input  1  clock, rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- WE  input  1  write enable from writeback.
- WADDR  input  ADDR_W  write register index.
- WDATA  input  XLEN  write data.
- RADDR1  input  ADDR_W  read port 1 index.
- RADDR2  input  ADDR_W  read port 2 index.
- RDATA1  output  XLEN  read port 1 data.
- RDATA2  output  XLEN  read port 2 data.
- WR_ONEHOT  output  NREG  registered one-hot of the write committed on the last edge; all zero if none.
- WR_VALID  output  1  registered: a write committed on the last edge.

Behaviour:
- Clock and reset (fixed): one clock, CLK; reset RST_N is asynchronous and active-low.
- Reset: while RST_N=0, all NREG registers are 0, WR_ONEHOT=0 and WR_VALID=0, independent of CLK.
  - Deassertion takes effect at the next rising edge.
  - Reset asserted mid-cycle discards any write not yet clocked.
- Write decode: the decoder sub-module produces dec[NREG] = (WE ? 1<<WADDR : 0). Exactly one or zero bits are set.
- Write commit: on each rising CLK with RST_N=1, reg[i] <= WDATA for the single i with dec[i]=1.
  - If ZERO_REG=1, dec[0] is masked: a write to index 0 commits nothing, and WR_VALID/WR_ONEHOT stay 0 for it.
- Trace: on the same edge, WR_ONEHOT <= masked dec and WR_VALID <= |masked dec. Both are cleared on the next edge if no write occurs.
- Read: RDATAn = reg[RADDRn] combinationally (zero latency).
  - If ZERO_REG=1 and RADDRn=0, RDATAn=0.
- Same-cycle read/write to one index without bypass: the read returns the old value; the new value is visible after the edge.
- Both read ports may address the same register; both return identical data.
- Latency: write-to-read is 1 cycle without bypass and 0 cycles with bypass.
- No X propagation: unwritten registers read 0 after reset.
- Width rules: WADDR/RADDR span the full 2**ADDR_W range, so there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if WE=1 and RADDRn==WADDR (and not index 0 when ZERO_REG=1), RDATAn=WDATA in the same cycle (write-first forwarding). This applies to each port independently.
- Undefined: read-before-write as described above. No bypass mux is synthesised.

Decomposition:
- Shared package/header regfile_pkg: XLEN and ADDR_W defaults, NREG derivation, ZERO index constant.
- Sub-module decoder_n (parameter N_IN): IN[N_IN], EN, OUT[2**N_IN]. It is a one-hot decoder and replaces the cascaded fixed-width decoders.
- Storage, read muxes, bypass and trace registers stay in regfile_decoded.

Test Plan:
- Reset: assert RST_N=0 mid-run after writing 0xDEADBEEF to x5 -> RDATA1 (RADDR1=5) reads 0x00000000 immediately, WR_VALID=0, WR_ONEHOT=0.
- Basic write/read: WE=1, WADDR=3, WDATA=0x12345678, one edge -> WR_VALID=1, WR_ONEHOT=0x00000008, RADDR2=3 gives 0x12345678; with WE=0 on the next edge, WR_VALID=0.
- x0 protection (ZERO_REG=1): WE=1, WADDR=0, WDATA=0xFFFFFFFF -> RDATA1 (RADDR1=0) stays 0, WR_VALID=0, WR_ONEHOT=0.
- Same-cycle hazard: x7=0x1 then WE=1, WADDR=7, WDATA=0x2, RADDR1=7 -> before the edge, RDATA1=0x1 without REGFILE_BYPASS_EN and 0x2 with it; after the edge, 0x2 in both builds.
- Sweep: write i*0x01010101 to each x1..x31 in turn, checking WR_ONEHOT=1<<i each cycle -> all reads match on both ports, x0=0.
- Parametrisation: ADDR_W=3, XLEN=16, ZERO_REG=0 -> write 0xABCD to x0 and 0x1234 to x7 -> read back 0xABCD and 0x1234, WR_ONEHOT 8 bits wide.
